// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: gives the loader exclusive access during boot, then
// favours the pipeline MEM stage while forcing an occasional loader slot.
module dm_port_arbiter #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pipe_memRead,
  input  logic              pipe_memWrite,
  input  logic [ADDR_W-1:0] pipe_addr,
  input  logic [DATA_W-1:0] pipe_wdata,
  output logic [DATA_W-1:0] pipe_rdata,
  output logic              pipe_stall,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  input  logic              ldr_done,
  output logic              ldr_gnt,
  output logic              ldr_rvalid,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              dm_memRead,
  output logic              dm_memWrite,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  input  logic [DATA_W-1:0] dm_rdata,
  output logic              boot_mode,
  output logic [CNT_W-1:0]  starve_cnt
);

  typedef enum logic [1:0] {BOOT, RUN, FORCE} state_t;

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(STARVE_LIMIT - 1);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  starveCnt_q, starveCnt_d;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              pipeAcc, pipeOwn, ldrGnt, ldrRead;

  assign pipeAcc = pipe_memRead | pipe_memWrite;
  assign ldrRead = ldrGnt & ~ldr_we;

  // Ownership decision; nobody is granted while reset is held.
  always_comb begin
    pipeOwn    = 1'b0;
    ldrGnt     = 1'b0;
    pipe_stall = 1'b0;
    if (!reset) begin
      case (state_q)
        BOOT: begin
          ldrGnt     = ldr_req;
          pipe_stall = pipeAcc;
        end
        RUN: begin
          if (pipeAcc) pipeOwn = 1'b1;
          else         ldrGnt  = ldr_req;
        end
        FORCE: begin
          if (ldr_req) begin
            ldrGnt     = 1'b1;
            pipe_stall = pipeAcc;
          end else begin
            pipeOwn = pipeAcc;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    dm_memRead  = 1'b0;
    dm_memWrite = 1'b0;
    dm_addr     = '0;
    dm_wdata    = '0;
    if (ldrGnt) begin
      dm_memRead  = ~ldr_we;
      dm_memWrite = ldr_we;
      dm_addr     = ldr_addr;
      dm_wdata    = ldr_wdata;
    end else if (pipeOwn) begin
      // A simultaneous read+write strobe is treated as a store.
      dm_memRead  = pipe_memRead & ~pipe_memWrite;
      dm_memWrite = pipe_memWrite;
      dm_addr     = pipe_addr;
      dm_wdata    = pipe_wdata;
    end
  end

  always_comb begin
    state_d     = state_q;
    starveCnt_d = '0;
    case (state_q)
      BOOT:  if (ldr_done) state_d = RUN;
      RUN: begin
        if (ldr_req && !ldrGnt) begin
          if (starveCnt_q == CntMax) state_d = FORCE;
          else                       starveCnt_d = starveCnt_q + 1'b1;
        end
      end
      FORCE: state_d = RUN;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= BOOT;
      starveCnt_q <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      starveCnt_q <= starveCnt_d;
      rvalid_q    <= ldrRead;
      if (ldrRead) rdata_q <= dm_rdata;
    end
  end

  assign pipe_rdata = pipeOwn ? dm_rdata : '0;
  assign ldr_gnt    = ldrGnt;
  assign ldr_rvalid = rvalid_q;
  assign ldr_rdata  = rdata_q;
  assign boot_mode  = (state_q == BOOT);
  assign starve_cnt = starveCnt_q;

endmodule
